hazard_scoreboard: RTL

- Parametrised successor to the fixed load-use hazard detector in the 5-stage RV32 pipeline.
- Tracks every in-flight destination register with a per-register countdown, so that execution units of variable latency (load, multiply, divide) can share one pipeline.
- Produces the ID-stage stall for three hazard types: RAW, WAW and shared-writeback-port conflicts.
- Sits beside the ID/EX register and drives the same stall/bubble path as the current Reg_Stall.

---
 rtl/hazard_scoreboard_pkg.sv | 31 +++
 rtl/hazard_scoreboard_wb_slot_ring.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 80 ++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: latency field, unit latencies and
// the bundled issue request seen at the ID stage.
package hazard_scoreboard_pkg;

    localparam int DEF_NREG       = 32;
    localparam int DEF_RF_ADDRESS = 5;
    localparam int DEF_MAX_LAT    = 7;
    localparam int DEF_LAT_W      = 3;

    typedef logic [DEF_LAT_W-1:0] lat_t;

    // Extra cycles after EX before each unit's result can be forwarded
    typedef enum lat_t {
        LAT_ALU  = 3'd0,
        LAT_LOAD = 3'd1,
        LAT_MUL  = 3'd3,
        LAT_DIV  = 3'd7
    } unit_lat_e;

    typedef struct packed {
        logic                      valid;
        logic [DEF_RF_ADDRESS-1:0] rs1;
        logic [DEF_RF_ADDRESS-1:0] rs2;
        logic                      use_rs1;
        logic                      use_rs2;
        logic                      wr;
        logic [DEF_RF_ADDRESS-1:0] rd;
        lat_t                      lat;
    } issue_req_t;

endpackage

// File: rtl/hazard_scoreboard_wb_slot_ring.sv
// Writeback-port reservation ring. Bit k of the ring means the shared
// writeback port is taken k cycles after an ALU op issued now; the ring
// advances one slot per cycle.
module wb_slot_ring
    import hazard_scoreboard_pkg::*;
#(
    parameter int MAX_LAT = DEF_MAX_LAT,
    parameter int LAT_W   = DEF_LAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reserve,
    input  logic [LAT_W-1:0] lat,
    output logic             conflict,
    output logic             busy
);

    logic [MAX_LAT:0] wb_resv;
    logic [MAX_LAT:0] resv_sh;
    logic [MAX_LAT:0] resv_set;

    assign resv_sh  = wb_resv >> 1;
    assign conflict = resv_sh[lat];
    assign busy     = |wb_resv;

    // One-hot slot claimed by the instruction being accepted this cycle
    always_comb begin
        resv_set = '0;
        if (reserve) begin
            resv_set[lat] = 1'b1;
        end
    end

    // Advance the ring and merge in the new reservation
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_resv <= '0;
        end else begin
            wb_resv <= resv_sh | resv_set;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: a per-register countdown of in-flight results
// plus a writeback-slot ring, producing the stall for RAW, WAW and
// shared-writeback-port hazards.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG       = DEF_NREG,
    parameter int RF_ADDRESS = DEF_RF_ADDRESS,
    parameter int MAX_LAT    = DEF_MAX_LAT,
    parameter int LAT_W      = DEF_LAT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [RF_ADDRESS-1:0] issue_rs1,
    input  logic [RF_ADDRESS-1:0] issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic                  issue_wr,
    input  logic [RF_ADDRESS-1:0] issue_rd,
    input  logic [LAT_W-1:0]      issue_lat,
    input  logic                  flush,
    output logic                  stall,
    output logic                  issue_fire,
    output logic [NREG-1:0]       pending,
    output logic                  busy
);

    logic [LAT_W-1:0] cnt [NREG];
    logic             raw;
    logic             waw;
    logic             sh;
    logic             record;
    logic             ring_busy;

    wb_slot_ring #(
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .reserve  (issue_fire & issue_wr),
        .lat      (issue_lat),
        .conflict (sh),
        .busy     (ring_busy)
    );

    // Hazard detection; stall and fire are held low during reset so that
    // stale counters never leak into the pipeline
    always_comb begin
        raw = (issue_use_rs1 && (issue_rs1 != '0) && (cnt[issue_rs1] != '0)) ||
              (issue_use_rs2 && (issue_rs2 != '0) && (cnt[issue_rs2] != '0));
        waw = issue_wr && (issue_rd != '0) && (cnt[issue_rd] > issue_lat);
        stall      = reset && issue_valid && !flush && (raw || waw || (issue_wr && sh));
        issue_fire = reset && issue_valid && !flush && !stall;
        record     = issue_fire && issue_wr && (issue_rd != '0);
    end

    // Count every in-flight result down; a newly accepted write reloads its entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!reset || i == 0) begin
                cnt[i] <= '0;
            end else if (record && (issue_rd == RF_ADDRESS'(i))) begin
                cnt[i] <= issue_lat;
            end else if (cnt[i] != '0) begin
                cnt[i] <= cnt[i] - LAT_W'(1);
            end
        end
    end

    // Per-register pending view and overall activity flag
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pending[r] = (cnt[r] != '0);
        end
        busy = (|pending) | ring_busy;
    end

endmodule
